// File: rtl/csr_exec_unit.sv
// CSR functional unit: one-cycle CSRRW/RS/RC(+I) with a speculative in-order pending-write buffer
// that retires to architectural CSRs on ROB commit, is cleared on flush, and forwards to younger ops.
module csr_exec_unit #(
  parameter int WORD       = 32,
  parameter int PEND_DEPTH = 4,
  parameter int ROB_DEPTH  = 32,
  parameter int ROB_AW     = $clog2(ROB_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_en,
  input  logic [WORD-1:0]   issue_rs1_value,
  input  logic [ROB_AW-1:0] issue_Pdst,
  input  logic [1:0]        issue_csr_op,
  input  logic [11:0]       issue_csr_addr,
  input  logic              issue_src_is_imm,
  input  logic [4:0]        issue_zimm,
  input  logic              rob_commit_en,
  input  logic [ROB_AW-1:0] rob_commit_rob,
  input  logic              rob_commit_br_taken,
  input  logic              rob_commit_exp_en,
  output logic              csr_fu_busy,
  output logic              wb_csr_valid,
  output logic [ROB_AW-1:0] wb_csr_dst_Paddr,
  output logic [WORD-1:0]   wb_csr_data,
  output logic              wb_csr_illegal
);

  localparam int PAW  = $clog2(PEND_DEPTH);
  localparam int NCSR = 5;
  localparam logic [2:0] CSR_NONE = 3'd7;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [WORD-1:0]   arch      [NCSR];
  logic [ROB_AW-1:0] pend_rob  [PEND_DEPTH];
  logic [11:0]       pend_addr [PEND_DEPTH];
  logic [WORD-1:0]   pend_data [PEND_DEPTH];
  logic [PAW-1:0]    head;
  logic [PAW-1:0]    tail;
  logic [PAW:0]      count;

  logic              flush;
  logic              accept;
  logic              illegal;
  logic              do_write;
  logic              retire;
  logic [2:0]        idx;
  logic [2:0]        head_idx;
  logic [WORD-1:0]   src;
  logic [WORD-1:0]   old_val;
  logic [WORD-1:0]   new_val;

  function automatic logic [2:0] csr_index(input logic [11:0] a);
    case (a)
      12'h300: csr_index = 3'd0;
      12'h305: csr_index = 3'd1;
      12'h340: csr_index = 3'd2;
      12'h341: csr_index = 3'd3;
      12'h342: csr_index = 3'd4;
      default: csr_index = CSR_NONE;
    endcase
  endfunction

  assign csr_fu_busy = (count == (PAW+1)'(PEND_DEPTH));
  assign flush       = rob_commit_br_taken | rob_commit_exp_en;
  assign head_idx    = csr_index(pend_addr[head]);

  always_comb begin
    idx     = csr_index(issue_csr_addr);
    illegal = (issue_csr_op == 2'b00) || (idx == CSR_NONE);
    src     = issue_src_is_imm ? {{(WORD-5){1'b0}}, issue_zimm} : issue_rs1_value;
    old_val = '0;
    if (!illegal) old_val = arch[idx];
    // Walk oldest to youngest so the youngest matching pending write wins.
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (((PAW+1)'(i) < count) && (pend_addr[head + PAW'(i)] == issue_csr_addr))
        old_val = pend_data[head + PAW'(i)];
    end
    case (issue_csr_op)
      OP_RW:   new_val = src;
      OP_RS:   new_val = old_val | src;
      OP_RC:   new_val = old_val & ~src;
      default: new_val = '0;
    endcase
    accept   = issue_en && !csr_fu_busy && !flush;
    do_write = accept && !illegal && ((issue_csr_op == OP_RW) || (src != '0));
    retire   = rob_commit_en && !rob_commit_exp_en && (count != '0) &&
               (pend_rob[head] == rob_commit_rob);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head             <= '0;
      tail             <= '0;
      count            <= '0;
      wb_csr_valid     <= 1'b0;
      wb_csr_dst_Paddr <= '0;
      wb_csr_data      <= '0;
      wb_csr_illegal   <= 1'b0;
      for (int k = 0; k < NCSR; k++) arch[k] <= '0;
    end else begin
      wb_csr_valid     <= accept;
      wb_csr_dst_Paddr <= accept ? issue_Pdst : '0;
      wb_csr_data      <= (accept && !illegal) ? old_val : '0;
      wb_csr_illegal   <= accept && illegal;
      // A retire in the same cycle as a branch flush still lands before the buffer clears.
      if (retire) arch[head_idx] <= pend_data[head];
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (retire)   head <= head + 1'b1;
        if (do_write) tail <= tail + 1'b1;
        case ({do_write, retire})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      pend_rob[tail]  <= issue_Pdst;
      pend_addr[tail] <= issue_csr_addr;
      pend_data[tail] <= new_val;
    end
  end

  // The issue queue must hold issue while the buffer is full.
  no_issue_when_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !(issue_en && csr_fu_busy));

endmodule

// File: tb/tb_csr_exec_unit.sv
// Bench for csr_exec_unit: hand vector table, corner sequences, and random traffic vs a queue-based model.
module tb_csr_exec_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_en = 1'b0;
  logic [31:0] issue_rs1_value = '0;
  logic [4:0]  issue_Pdst = '0;
  logic [1:0]  issue_csr_op = '0;
  logic [11:0] issue_csr_addr = '0;
  logic        issue_src_is_imm = 1'b0;
  logic [4:0]  issue_zimm = '0;
  logic        rob_commit_en = 1'b0;
  logic [4:0]  rob_commit_rob = '0;
  logic        rob_commit_br_taken = 1'b0;
  logic        rob_commit_exp_en = 1'b0;
  logic        csr_fu_busy;
  logic        wb_csr_valid;
  logic [4:0]  wb_csr_dst_Paddr;
  logic [31:0] wb_csr_data;
  logic        wb_csr_illegal;

  csr_exec_unit #(.WORD(32), .PEND_DEPTH(DEPTH), .ROB_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_en(issue_en), .issue_rs1_value(issue_rs1_value), .issue_Pdst(issue_Pdst),
    .issue_csr_op(issue_csr_op), .issue_csr_addr(issue_csr_addr),
    .issue_src_is_imm(issue_src_is_imm), .issue_zimm(issue_zimm),
    .rob_commit_en(rob_commit_en), .rob_commit_rob(rob_commit_rob),
    .rob_commit_br_taken(rob_commit_br_taken), .rob_commit_exp_en(rob_commit_exp_en),
    .csr_fu_busy(csr_fu_busy), .wb_csr_valid(wb_csr_valid), .wb_csr_dst_Paddr(wb_csr_dst_Paddr),
    .wb_csr_data(wb_csr_data), .wb_csr_illegal(wb_csr_illegal)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [11:0] addr;
    logic        imm;
    logic [4:0]  zimm;
    logic [31:0] rs1;
    logic [4:0]  pdst;
    logic        cen;
    logic [4:0]  crob;
    logic        br;
    logic        ex;
  } op_t;

  typedef struct {
    op_t         i;
    logic        ev;
    logic [31:0] ed;
    logic        eil;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [4:0]  rob;
    logic [11:0] addr;
    logic [31:0] data;
  } pend_t;

  pend_t       mq[$];
  logic [31:0] march[logic [11:0]];

  function automatic op_t iss(logic [1:0] op, logic [11:0] a, logic imm, logic [4:0] z,
                              logic [31:0] rs1, logic [4:0] tag);
    op_t o;
    o = '{1'b1, op, a, imm, z, rs1, tag, 1'b0, 5'd0, 1'b0, 1'b0};
    return o;
  endfunction

  function automatic op_t cmt(logic [4:0] tag, logic br, logic ex);
    op_t o;
    o = '{1'b0, 2'b00, 12'h000, 1'b0, 5'd0, 32'd0, 5'd0, 1'b1, tag, br, ex};
    return o;
  endfunction

  task automatic arch_reset();
    march.delete();
    march[12'h300] = '0; march[12'h305] = '0; march[12'h340] = '0;
    march[12'h341] = '0; march[12'h342] = '0;
    mq.delete();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock: drive o, step the model, then check writeback and busy after the edge.
  task automatic cyc(input op_t o);
    logic        flush, acc, ill, wr;
    logic [31:0] src, old, nv;
    @(negedge clk);
    issue_en = o.en; issue_csr_op = o.op; issue_csr_addr = o.addr;
    issue_src_is_imm = o.imm; issue_zimm = o.zimm; issue_rs1_value = o.rs1; issue_Pdst = o.pdst;
    rob_commit_en = o.cen; rob_commit_rob = o.crob;
    rob_commit_br_taken = o.br; rob_commit_exp_en = o.ex;
    flush = o.br | o.ex;
    acc   = o.en && (mq.size() < DEPTH) && !flush;
    ill   = (o.op == 2'b00) || !march.exists(o.addr);
    src   = o.imm ? {27'd0, o.zimm} : o.rs1;
    old   = '0;
    if (!ill) begin
      old = march[o.addr];
      foreach (mq[k]) if (mq[k].addr == o.addr) old = mq[k].data;
    end
    nv = (o.op == 2'b01) ? src : (o.op == 2'b10) ? (old | src) : (old & ~src);
    wr = acc && !ill && ((o.op == 2'b01) || (src != 0));
    @(posedge clk);
    #1;
    if (o.cen && !o.ex && mq.size() > 0 && mq[0].rob == o.crob) begin
      march[mq[0].addr] = mq[0].data;
      void'(mq.pop_front());
    end
    if (flush) mq.delete();
    else if (wr) mq.push_back('{o.pdst, o.addr, nv});
    chk("model_wb_valid", 32'(wb_csr_valid), 32'(acc));
    if (acc) begin
      chk("model_wb_tag", 32'(wb_csr_dst_Paddr), 32'(o.pdst));
      chk("model_wb_data", wb_csr_data, ill ? 32'd0 : old);
      chk("model_wb_illegal", 32'(wb_csr_illegal), 32'(ill));
    end
    chk("model_busy", 32'(csr_fu_busy), 32'(mq.size() == DEPTH));
  endtask

  vec_t tv[21];
  op_t  idle;
  op_t  r;
  logic [11:0] addrs[6];

  initial begin
    idle = '{1'b0, 2'b00, 12'h000, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
    addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h340;
    addrs[3] = 12'h341; addrs[4] = 12'h342; addrs[5] = 12'h7C0;
    tv[0]  = '{iss(2'b01, 12'h340, 1'b0, 5'd0, 32'h1234, 5'd3), 1'b1, 32'h0,    1'b0, 1'b0};
    tv[1]  = '{cmt(5'd3, 1'b0, 1'b0),                          1'b0, 32'h0,    1'b0, 1'b0};
    tv[2]  = '{iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0,    5'd4), 1'b1, 32'h1234, 1'b0, 1'b0};
    tv[3]  = '{iss(2'b01, 12'h340, 1'b0, 5'd0, 32'hA5,   5'd5), 1'b1, 32'h1234, 1'b0, 1'b0};
    tv[4]  = '{iss(2'b10, 12'h340, 1'b0, 5'd0, 32'h0F,   5'd6), 1'b1, 32'hA5,   1'b0, 1'b0};
    tv[5]  = '{cmt(5'd5, 1'b0, 1'b0),                          1'b0, 32'h0,    1'b0, 1'b0};
    tv[6]  = '{cmt(5'd6, 1'b0, 1'b0),                          1'b0, 32'h0,    1'b0, 1'b0};
    tv[7]  = '{iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0,    5'd7), 1'b1, 32'hAF,   1'b0, 1'b0};
    tv[8]  = '{iss(2'b10, 12'h305, 1'b1, 5'd0, 32'h0,    5'd8), 1'b1, 32'h0,    1'b0, 1'b0};
    tv[9]  = '{cmt(5'd8, 1'b0, 1'b0),                          1'b0, 32'h0,    1'b0, 1'b0};
    tv[10] = '{iss(2'b10, 12'h305, 1'b1, 5'd0, 32'h0,    5'd9), 1'b1, 32'h0,    1'b0, 1'b0};
    tv[11] = '{iss(2'b01, 12'h7C0, 1'b0, 5'd0, 32'h5,   5'd10), 1'b1, 32'h0,    1'b1, 1'b0};
    tv[12] = '{iss(2'b00, 12'h340, 1'b0, 5'd0, 32'h5,   5'd11), 1'b1, 32'h0,    1'b1, 1'b0};
    tv[13] = '{iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0,   5'd12), 1'b1, 32'hAF,   1'b0, 1'b0};
    tv[14] = '{iss(2'b11, 12'h340, 1'b0, 5'd0, 32'h0F,  5'd13), 1'b1, 32'hAF,   1'b0, 1'b0};
    tv[15] = '{iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0,   5'd14), 1'b1, 32'hA0,   1'b0, 1'b0};
    tv[16] = '{cmt(5'd13, 1'b0, 1'b0),                         1'b0, 32'h0,    1'b0, 1'b0};
    tv[17] = '{iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0,   5'd15), 1'b1, 32'hA0,   1'b0, 1'b0};
    tv[18] = '{iss(2'b10, 12'h300, 1'b1, 5'h1F, 32'hFFFF, 5'd16), 1'b1, 32'h0,  1'b0, 1'b0};
    tv[19] = '{iss(2'b10, 12'h300, 1'b1, 5'd0, 32'h0,   5'd17), 1'b1, 32'h1F,   1'b0, 1'b0};
    tv[20] = '{cmt(5'd16, 1'b0, 1'b0),                         1'b0, 32'h0,    1'b0, 1'b0};

    arch_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wb_valid", 32'(wb_csr_valid), 32'd0);
    chk("reset_wb_data", wb_csr_data, 32'd0);
    chk("reset_wb_illegal", 32'(wb_csr_illegal), 32'd0);
    chk("reset_busy", 32'(csr_fu_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 21; v++) begin
      cyc(tv[v].i);
      chk($sformatf("vec%0d_valid", v), 32'(wb_csr_valid), 32'(tv[v].ev));
      if (tv[v].ev) begin
        chk($sformatf("vec%0d_tag", v), 32'(wb_csr_dst_Paddr), 32'(tv[v].i.pdst));
        chk($sformatf("vec%0d_data", v), wb_csr_data, tv[v].ed);
        chk($sformatf("vec%0d_illegal", v), 32'(wb_csr_illegal), 32'(tv[v].eil));
      end
      chk($sformatf("vec%0d_busy", v), 32'(csr_fu_busy), 32'(tv[v].eb));
    end

    // Branch flush discards two pending writes; arch keeps pre-flush value.
    cyc(iss(2'b01, 12'h340, 1'b0, 5'd0, 32'h111, 5'd1));
    cyc(iss(2'b01, 12'h341, 1'b0, 5'd0, 32'h222, 5'd2));
    cyc(cmt(5'd9, 1'b1, 1'b0));
    cyc(iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0, 5'd3));
    chk("flush_read_mscratch", wb_csr_data, 32'hA0);
    cyc(iss(2'b10, 12'h341, 1'b1, 5'd0, 32'h0, 5'd4));
    chk("flush_read_mepc", wb_csr_data, 32'h0);

    // Retire and branch flush in the same cycle: head retires, younger entry dropped.
    cyc(iss(2'b01, 12'h342, 1'b0, 5'd0, 32'h33, 5'd4));
    cyc(iss(2'b01, 12'h342, 1'b0, 5'd0, 32'h44, 5'd5));
    cyc(cmt(5'd4, 1'b1, 1'b0));
    cyc(iss(2'b10, 12'h342, 1'b1, 5'd0, 32'h0, 5'd6));
    chk("retire_br_mcause", wb_csr_data, 32'h33);

    // Exception flush never retires, even on a tag match.
    cyc(iss(2'b01, 12'h341, 1'b0, 5'd0, 32'h55, 5'd6));
    cyc(cmt(5'd6, 1'b0, 1'b1));
    r = iss(2'b01, 12'h341, 1'b0, 5'd0, 32'h66, 5'd7);
    r.cen = 1'b1; r.br = 1'b1;
    cyc(r);
    chk("flush_cycle_issue_dropped", 32'(wb_csr_valid), 32'd0);
    cyc(iss(2'b10, 12'h341, 1'b1, 5'd0, 32'h0, 5'd8));
    chk("exp_no_retire_mepc", wb_csr_data, 32'h0);

    // Full buffer raises busy; a single retire clears it next cycle.
    for (int t = 0; t < DEPTH; t++)
      cyc(iss(2'b01, 12'h305, 1'b0, 5'd0, 32'h100 + t, 5'(20 + t)));
    chk("busy_when_full", 32'(csr_fu_busy), 32'd1);
    cyc(cmt(5'd20, 1'b0, 1'b0));
    chk("busy_after_retire", 32'(csr_fu_busy), 32'd0);
    cyc(iss(2'b10, 12'h305, 1'b1, 5'd0, 32'h0, 5'd9));
    chk("youngest_forward_mtvec", wb_csr_data, 32'h103);
    for (int t = 1; t < DEPTH; t++) cyc(cmt(5'(20 + t), 1'b0, 1'b0));

    // Reset with a pending write: buffer discarded, arch back to zero.
    cyc(iss(2'b01, 12'h340, 1'b0, 5'd0, 32'h77, 5'd8));
    @(negedge clk);
    rst_n = 1'b0;
    issue_en = 1'b0; rob_commit_en = 1'b0; rob_commit_br_taken = 1'b0; rob_commit_exp_en = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_wb_valid", 32'(wb_csr_valid), 32'd0);
    chk("midreset_busy", 32'(csr_fu_busy), 32'd0);
    arch_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(iss(2'b10, 12'h340, 1'b1, 5'd0, 32'h0, 5'd9));
    chk("midreset_mscratch", wb_csr_data, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      r = idle;
      r.en   = ($urandom_range(0, 2) != 0) && (mq.size() < DEPTH);
      r.op   = 2'($urandom_range(0, 3));
      r.addr = addrs[$urandom_range(0, 5)];
      r.imm  = 1'($urandom_range(0, 1));
      r.zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      r.rs1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      r.pdst = 5'($urandom);
      r.cen  = 1'($urandom_range(0, 1));
      r.crob = (mq.size() > 0 && $urandom_range(0, 3) != 0) ? mq[0].rob : 5'($urandom);
      r.br   = ($urandom_range(0, 15) == 0);
      r.ex   = ($urandom_range(0, 19) == 0);
      if (r.br || r.ex) r.cen = 1'b1;
      cyc(r);
    end

    cyc(idle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
